aibcr3aux_cndn_dlycal: RTL and testbench



---
 rtl/aibcr3aux_dlycal_pkg.sv | 34 +++
 rtl/aibcr3aux_dlycal_vote.sv | 58 +++++
 rtl/aibcr3aux_cndn_dlycal.sv | 163 ++++++++++++++++
 tb/tb_aibcr3aux_cndn_dlycal.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/aibcr3aux_dlycal_pkg.sv
// rtl/aibcr3aux_dlycal_pkg.sv - shared types and defaults for the aux strobe delay calibrator
package aibcr3aux_dlycal_pkg;

  // Calibration controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  // Outcome of one majority vote; NONE marks "no step taken yet"
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2,
    DIR_TIE  = 2'd3
  } dir_e;

  localparam int CODE_W_DEF     = 4;
  localparam int CODE_INIT_DEF  = 8;
  localparam int VOTE_N_DEF     = 8;
  localparam int SETTLE_CYC_DEF = 16;
  localparam int MAX_STEPS_DEF  = 16;

  // True when the new direction undoes the previous step (the lock condition)
  function automatic logic dir_reversed(input dir_e last_dir, input dir_e new_dir);
    return ((last_dir == DIR_UP) && (new_dir == DIR_DN)) ||
           ((last_dir == DIR_DN) && (new_dir == DIR_UP));
  endfunction

endpackage

// File: rtl/aibcr3aux_dlycal_vote.sv
// rtl/aibcr3aux_dlycal_vote.sv - phase-detector vote counter and majority compare
module aibcr3aux_dlycal_vote
  import aibcr3aux_dlycal_pkg::*;
#(
  parameter int VOTE_N = VOTE_N_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic pd_valid,
  input  logic pd_early,
  output dir_e dir,
  output logic vote_done
);

  localparam int CW = $clog2(VOTE_N + 1);
  localparam logic [CW-1:0] VOTE_MAX  = CW'(VOTE_N);
  localparam logic [CW-1:0] VOTE_LAST = CW'(VOTE_N - 1);
  localparam logic [CW-1:0] VOTE_HALF = CW'(VOTE_N / 2);

  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] ecnt_q, ecnt_d;

  // Count pulses and early votes; saturate at VOTE_N so nothing wraps
  always_comb begin
    pcnt_d    = pcnt_q;
    ecnt_d    = ecnt_q;
    vote_done = 1'b0;
    if (clr) begin
      pcnt_d = '0;
      ecnt_d = '0;
    end else if (en && pd_valid && (pcnt_q < VOTE_MAX)) begin
      pcnt_d    = pcnt_q + 1'b1;
      ecnt_d    = pd_early ? ecnt_q + 1'b1 : ecnt_q;
      vote_done = (pcnt_q == VOTE_LAST);
    end
  end

  // Majority compare on the registered totals, valid the cycle after vote_done
  always_comb begin
    if (ecnt_q > VOTE_HALF)      dir = DIR_UP;
    else if (ecnt_q < VOTE_HALF) dir = DIR_DN;
    else                         dir = DIR_TIE;
  end

  // Vote counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      ecnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      ecnt_q <= ecnt_d;
    end
  end

endmodule

// File: rtl/aibcr3aux_cndn_dlycal.sv
// rtl/aibcr3aux_cndn_dlycal.sv - aux strobe input-delay calibration controller
module aibcr3aux_cndn_dlycal
  import aibcr3aux_dlycal_pkg::*;
#(
  parameter int CODE_W     = CODE_W_DEF,
  parameter int CODE_INIT  = CODE_INIT_DEF,
  parameter int VOTE_N     = VOTE_N_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int MAX_STEPS  = MAX_STEPS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cal_start,
  input  logic              csr_man_en,
  input  logic [CODE_W-1:0] csr_man_code,
  input  logic              pd_valid,
  input  logic              pd_early,
  output logic [CODE_W-1:0] dly_code,
  output logic              dly_ovrden,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_err
);

  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int STW = $clog2(MAX_STEPS);
  localparam logic [CODE_W-1:0] CODE_RST  = CODE_W'(CODE_INIT);
  localparam logic [CODE_W-1:0] CODE_MAX  = {CODE_W{1'b1}};
  localparam logic [SCW-1:0]    SETTLE_LAST = SCW'(SETTLE_CYC - 1);
  localparam logic [STW-1:0]    STEP_LAST   = STW'(MAX_STEPS - 1);

  state_e            state_q, state_d;
  dir_e              last_dir_q, last_dir_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              ovrden_q, ovrden_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [SCW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [STW-1:0]    step_cnt_q, step_cnt_d;

  dir_e vote_dir;
  logic vote_done;
  logic vote_clr;
  logic vote_en;

  // Counters are cleared throughout SETTLE so SAMPLE always starts from zero
  assign vote_clr = (state_q == ST_SETTLE);
  assign vote_en  = (state_q == ST_SAMPLE) && !csr_man_en;

  aibcr3aux_dlycal_vote #(
    .VOTE_N(VOTE_N)
  ) u_vote (
    .clk      (clk),
    .rst      (rst),
    .clr      (vote_clr),
    .en       (vote_en),
    .pd_valid (pd_valid),
    .pd_early (pd_early),
    .dir      (vote_dir),
    .vote_done(vote_done)
  );

  // Next-state and next-output logic; manual override beats everything but rst
  always_comb begin
    state_d      = state_q;
    last_dir_d   = last_dir_q;
    code_d       = code_q;
    ovrden_d     = ovrden_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    settle_cnt_d = settle_cnt_q;
    step_cnt_d   = step_cnt_q;

    if (csr_man_en) begin
      state_d      = ST_IDLE;
      code_d       = csr_man_code;
      ovrden_d     = 1'b1;
      busy_d       = 1'b0;
      settle_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (cal_start) begin
            state_d      = ST_SETTLE;
            code_d       = CODE_RST;
            ovrden_d     = 1'b1;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            err_d        = 1'b0;
            settle_cnt_d = '0;
            step_cnt_d   = '0;
            last_dir_d   = DIR_NONE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_d = '0;
            state_d      = ST_SAMPLE;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (vote_done) state_d = ST_DECIDE;
        end
        ST_DECIDE: begin
          if ((vote_dir == DIR_TIE) || dir_reversed(last_dir_q, vote_dir)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (((vote_dir == DIR_UP) && (code_q == CODE_MAX)) ||
                       ((vote_dir == DIR_DN) && (code_q == '0)) ||
                       (step_cnt_q == STEP_LAST)) begin
            state_d = ST_ERR;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            code_d       = (vote_dir == DIR_UP) ? code_q + 1'b1 : code_q - 1'b1;
            step_cnt_d   = step_cnt_q + 1'b1;
            last_dir_d   = vote_dir;
            settle_cnt_d = '0;
            state_d      = ST_SETTLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Controller registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_dir_q   <= DIR_NONE;
      code_q       <= CODE_RST;
      ovrden_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      settle_cnt_q <= '0;
      step_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_dir_q   <= last_dir_d;
      code_q       <= code_d;
      ovrden_q     <= ovrden_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      settle_cnt_q <= settle_cnt_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  assign dly_code   = code_q;
  assign dly_ovrden = ovrden_q;
  assign cal_busy   = busy_q;
  assign cal_done   = done_q;
  assign cal_err    = err_q;

endmodule

// File: tb/tb_aibcr3aux_cndn_dlycal.sv
// tb/tb_aibcr3aux_cndn_dlycal.sv - directed self-checking bench for the delay calibrator
module tb_aibcr3aux_cndn_dlycal;
  import aibcr3aux_dlycal_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cal_start;
  logic       csr_man_en;
  logic [3:0] csr_man_code;
  logic       pd_valid;
  logic       pd_early;
  logic [3:0] dly_code;
  logic       dly_ovrden;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aibcr3aux_cndn_dlycal dut (
    .clk         (clk),
    .rst         (rst),
    .cal_start   (cal_start),
    .csr_man_en  (csr_man_en),
    .csr_man_code(csr_man_code),
    .pd_valid    (pd_valid),
    .pd_early    (pd_early),
    .dly_code    (dly_code),
    .dly_ovrden  (dly_ovrden),
    .cal_busy    (cal_busy),
    .cal_done    (cal_done),
    .cal_err     (cal_err)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_cal();
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
  endtask

  task automatic wait_sample();
    int n;
    n = 0;
    while ((dut.state_q != ST_SAMPLE) && (n < 60)) begin
      step();
      n++;
    end
    check("reach_sample", 32'(dut.state_q == ST_SAMPLE), 32'd1);
  endtask

  // One full vote round: 8 back-to-back pulses with early bits from pat, then DECIDE
  task automatic vote_round(input logic [7:0] pat);
    wait_sample();
    for (int i = 0; i < 8; i++) begin
      pd_valid = 1'b1;
      pd_early = pat[i];
      step();
    end
    pd_valid = 1'b0;
    pd_early = 1'b0;
    check("in_decide", 32'(dut.state_q), 32'(ST_DECIDE));
    step();
  endtask

  initial begin
    rst          = 1'b1;
    cal_start    = 1'b0;
    csr_man_en   = 1'b0;
    csr_man_code = 4'd0;
    pd_valid     = 1'b0;
    pd_early     = 1'b0;

    // 1: reset then idle
    step(2);
    rst = 1'b0;
    step(20);
    check("t1_code", 32'(dly_code), 32'd8);
    check("t1_ovrden", 32'(dly_ovrden), 32'd0);
    check("t1_busy", 32'(cal_busy), 32'd0);
    check("t1_done", 32'(cal_done), 32'd0);
    check("t1_err", 32'(cal_err), 32'd0);

    // 2: three UP rounds then a reversal locks at 11
    start_cal();
    check("t2_start_code", 32'(dly_code), 32'd8);
    check("t2_start_ovrden", 32'(dly_ovrden), 32'd1);
    check("t2_start_busy", 32'(cal_busy), 32'd1);
    vote_round(8'hFF);
    check("t2_code9", 32'(dly_code), 32'd9);
    vote_round(8'hFF);
    check("t2_code10", 32'(dly_code), 32'd10);
    vote_round(8'hFF);
    check("t2_code11", 32'(dly_code), 32'd11);
    check("t2_busy_mid", 32'(cal_busy), 32'd1);
    vote_round(8'h00);
    check("t2_lock_code", 32'(dly_code), 32'd11);
    check("t2_lock_busy", 32'(cal_busy), 32'd0);
    check("t2_lock_done", 32'(cal_done), 32'd1);
    check("t2_lock_state", 32'(dut.state_q), 32'(ST_DONE));
    step(5);
    check("t2_hold_code", 32'(dly_code), 32'd11);
    check("t2_hold_ovrden", 32'(dly_ovrden), 32'd1);

    // 3: always late, walk down to 0 then saturate into ERR
    start_cal();
    check("t3_start_code", 32'(dly_code), 32'd8);
    check("t3_start_done", 32'(cal_done), 32'd0);
    for (int k = 7; k >= 0; k--) begin
      vote_round(8'h00);
      check("t3_code_dn", 32'(dly_code), 32'(k));
    end
    check("t3_busy_mid", 32'(cal_busy), 32'd1);
    vote_round(8'h00);
    check("t3_err_code", 32'(dly_code), 32'd0);
    check("t3_err_flag", 32'(cal_err), 32'd1);
    check("t3_err_busy", 32'(cal_busy), 32'd0);
    check("t3_err_done", 32'(cal_done), 32'd0);
    check("t3_err_state", 32'(dut.state_q), 32'(ST_ERR));

    // 4: exact 4/8 tie on first decision
    start_cal();
    check("t4_start_err", 32'(cal_err), 32'd0);
    vote_round(8'b0101_0101);
    check("t4_code", 32'(dly_code), 32'd8);
    check("t4_done", 32'(cal_done), 32'd1);
    check("t4_busy", 32'(cal_busy), 32'd0);
    check("t4_steps", 32'(dut.step_cnt_q), 32'd0);

    // 5: manual override in the middle of SAMPLE at code 10
    start_cal();
    vote_round(8'hFF);
    vote_round(8'hFF);
    check("t5_code10", 32'(dly_code), 32'd10);
    wait_sample();
    for (int i = 0; i < 3; i++) begin
      pd_valid = 1'b1;
      pd_early = 1'b1;
      step();
    end
    csr_man_en   = 1'b1;
    csr_man_code = 4'd3;
    step();
    check("t5_man_code", 32'(dly_code), 32'd3);
    check("t5_man_busy", 32'(cal_busy), 32'd0);
    check("t5_man_ovrden", 32'(dly_ovrden), 32'd1);
    check("t5_man_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("t5_man_done", 32'(cal_done), 32'd0);
    step(6);
    check("t5_pd_ignored", 32'(dly_code), 32'd3);
    csr_man_code = 4'd13;
    step();
    check("t5_track", 32'(dly_code), 32'd13);
    csr_man_code = 4'd3;
    step();
    pd_valid   = 1'b0;
    pd_early   = 1'b0;
    csr_man_en = 1'b0;
    csr_man_code = 4'd7;
    step(4);
    check("t5_hold_code", 32'(dly_code), 32'd3);
    check("t5_hold_ovrden", 32'(dly_ovrden), 32'd1);
    check("t5_hold_state", 32'(dut.state_q), 32'(ST_IDLE));

    // 6: reset during SETTLE at code 12, then a clean rerun of test 2
    start_cal();
    for (int k = 9; k <= 12; k++) begin
      vote_round(8'hFF);
      check("t6_code_up", 32'(dly_code), 32'(k));
    end
    check("t6_in_settle", 32'(dut.state_q), 32'(ST_SETTLE));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_code", 32'(dly_code), 32'd8);
    check("t6_rst_ovrden", 32'(dly_ovrden), 32'd0);
    check("t6_rst_busy", 32'(cal_busy), 32'd0);
    check("t6_rst_done", 32'(cal_done), 32'd0);
    check("t6_rst_err", 32'(cal_err), 32'd0);
    check("t6_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    start_cal();
    vote_round(8'hFF);
    vote_round(8'hFF);
    vote_round(8'hFF);
    check("t6_rerun_code11", 32'(dly_code), 32'd11);
    vote_round(8'b0000_0001);
    check("t6_rerun_lock", 32'(dly_code), 32'd11);
    check("t6_rerun_done", 32'(cal_done), 32'd1);
    check("t6_rerun_busy", 32'(cal_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
